// File: rtl/rx_descrambler_sync_pkg.sv
// Shared PCS definitions: sync-header codes, lock thresholds, lock FSM encoding
// and the 64b/66b descrambler polynomial geometry.
package rx_descrambler_sync_pkg;

  // Sync-header codes for 64b/66b blocks
  localparam logic [1:0] SyncHdrData = 2'b01;
  localparam logic [1:0] SyncHdrCtrl = 2'b10;

  // Block-lock thresholds: window length and invalid-header limit within a window
  localparam int unsigned ShCntLock    = 64;
  localparam int unsigned ShInvldLimit = 16;

  // Counter widths sized to hold the thresholds themselves (0..64, 0..16)
  localparam int unsigned ShCntW   = 7;
  localparam int unsigned ShInvldW = 5;

  // Self-synchronous scrambler x^58 + x^39 + 1
  localparam int unsigned ScrHistW = 58;
  localparam int unsigned ScrTap   = 39;

  // Lock FSM states
  typedef enum logic [1:0] {
    StResetCnt = 2'd0,
    StTestSh   = 2'd1,
    StSlipHold = 2'd2
  } lock_state_e;

  // Only 01 and 10 are legal sync headers
  function automatic logic sh_is_valid(input logic [1:0] hdr);
    return (hdr == SyncHdrData) || (hdr == SyncHdrCtrl);
  endfunction

endpackage

// File: rtl/descrambler_core.sv
// Combinational one-word step of the x^58 + x^39 + 1 self-synchronous descrambler.
// hist holds the previous 58 received scrambled bits, hist[0] oldest, hist[57] newest.
module descrambler_core
  import rx_descrambler_sync_pkg::*;
#(
  parameter int unsigned DataWidth = 64
) (
  input  logic [ScrHistW-1:0]  hist,
  input  logic [DataWidth-1:0] scr_data,
  output logic [DataWidth-1:0] descr_data,
  output logic [ScrHistW-1:0]  next_hist
);

  // ext[j] is received stream bit (n0 - 58 + j), n0 being the position of scr_data[0]
  logic [DataWidth+ScrHistW-1:0] ext;

  assign ext = {scr_data, hist};

  // out[n] = r[n] ^ r[n-39] ^ r[n-58]
  always_comb begin
    descr_data = '0;
    for (int unsigned i = 0; i < DataWidth; i++) begin
      descr_data[i] = ext[i + ScrHistW] ^ ext[i + ScrHistW - ScrTap] ^ ext[i];
    end
  end

  // The newest 58 scrambled bits become the history for the next word
  assign next_hist = ext[DataWidth+ScrHistW-1 -: ScrHistW];

endmodule

// File: rtl/rx_descrambler_sync.sv
// 64b/66b receive descrambler with sync-header block-lock state machine.
// Every valid block is descrambled and forwarded with one cycle of latency; the
// lock FSM watches the sync headers and requests one-bit slips from the gearbox.
module rx_descrambler_sync
  import rx_descrambler_sync_pkg::*;
#(
  parameter int unsigned PCS_DATA_WIDTH = 64,
  // Must be at least 1: valid blocks ignored after each slip
  parameter int unsigned SLIP_WAIT      = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [PCS_DATA_WIDTH-1:0] in_data,
  input  logic [1:0]                in_header,
  input  logic                      in_valid,
  output logic [PCS_DATA_WIDTH-1:0] out_data,
  output logic [1:0]                out_header,
  output logic                      out_valid,
  output logic                      block_lock,
  output logic                      slip
);

  localparam int unsigned WaitW = (SLIP_WAIT > 1) ? $clog2(SLIP_WAIT) : 1;

  // Datapath state
  logic [ScrHistW-1:0]       hist_q;
  logic [ScrHistW-1:0]       next_hist;
  logic [PCS_DATA_WIDTH-1:0] descr_data;
  logic [PCS_DATA_WIDTH-1:0] out_data_q;
  logic [1:0]                out_header_q;
  logic                      out_valid_q;

  // Lock FSM state
  lock_state_e         state_q, state_d;
  logic [ShCntW-1:0]   sh_cnt_q, sh_cnt_d;
  logic [ShInvldW-1:0] sh_invld_cnt_q, sh_invld_cnt_d;
  logic [WaitW-1:0]    wait_cnt_q, wait_cnt_d;
  logic                lock_q, lock_d;
  logic                slip_q, slip_d;

  logic                hdr_ok;
  logic [ShCntW-1:0]   sh_cnt_inc;
  logic [ShInvldW-1:0] sh_invld_inc;
  logic                window_done;
  logic                invld_limit;
  logic                wait_done;

  descrambler_core #(
    .DataWidth (PCS_DATA_WIDTH)
  ) u_core (
    .hist       (hist_q),
    .scr_data   (in_data),
    .descr_data (descr_data),
    .next_hist  (next_hist)
  );

  // Descrambler history and registered outputs; history only advances on valid blocks
  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q       <= '1;
      out_data_q   <= '0;
      out_header_q <= '0;
      out_valid_q  <= 1'b0;
    end else begin
      out_valid_q <= in_valid;
      if (in_valid) begin
        hist_q       <= next_hist;
        out_data_q   <= descr_data;
        out_header_q <= in_header;
      end
    end
  end

  assign hdr_ok       = sh_is_valid(in_header);
  assign sh_cnt_inc   = sh_cnt_q + ShCntW'(1);
  assign sh_invld_inc = sh_invld_cnt_q + ShInvldW'(1);
  assign window_done  = (sh_cnt_inc == ShCntW'(ShCntLock));
  assign invld_limit  = (sh_invld_inc == ShInvldW'(ShInvldLimit));
  assign wait_done    = (wait_cnt_q == WaitW'(SLIP_WAIT - 1));

  // Lock FSM registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StResetCnt;
      sh_cnt_q       <= '0;
      sh_invld_cnt_q <= '0;
      wait_cnt_q     <= '0;
      lock_q         <= 1'b0;
      slip_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      sh_cnt_q       <= sh_cnt_d;
      sh_invld_cnt_q <= sh_invld_cnt_d;
      wait_cnt_q     <= wait_cnt_d;
      lock_q         <= lock_d;
      slip_q         <= slip_d;
    end
  end

  // Lock FSM next state; nothing moves on cycles without a valid block.
  // The block seen in StResetCnt is not header-tested.
  always_comb begin
    state_d        = state_q;
    sh_cnt_d       = sh_cnt_q;
    sh_invld_cnt_d = sh_invld_cnt_q;
    wait_cnt_d     = wait_cnt_q;
    lock_d         = lock_q;
    slip_d         = 1'b0;

    if (in_valid) begin
      unique case (state_q)
        StResetCnt: begin
          sh_cnt_d       = '0;
          sh_invld_cnt_d = '0;
          state_d        = StTestSh;
        end

        StTestSh: begin
          if (!lock_q) begin
            if (!hdr_ok) begin
              slip_d         = 1'b1;
              sh_cnt_d       = '0;
              sh_invld_cnt_d = '0;
              wait_cnt_d     = '0;
              state_d        = StSlipHold;
            end else if (window_done) begin
              lock_d         = 1'b1;
              sh_cnt_d       = '0;
              sh_invld_cnt_d = '0;
            end else begin
              sh_cnt_d = sh_cnt_inc;
            end
          end else begin
            // Losing lock takes priority over completing the window
            if (!hdr_ok && invld_limit) begin
              lock_d         = 1'b0;
              slip_d         = 1'b1;
              sh_cnt_d       = '0;
              sh_invld_cnt_d = '0;
              wait_cnt_d     = '0;
              state_d        = StSlipHold;
            end else if (window_done) begin
              sh_cnt_d       = '0;
              sh_invld_cnt_d = '0;
            end else begin
              sh_cnt_d = sh_cnt_inc;
              if (!hdr_ok) begin
                sh_invld_cnt_d = sh_invld_inc;
              end
            end
          end
        end

        StSlipHold: begin
          if (wait_done) begin
            wait_cnt_d = '0;
            state_d    = StResetCnt;
          end else begin
            wait_cnt_d = wait_cnt_q + WaitW'(1);
          end
        end

        default: begin
          state_d = StResetCnt;
        end
      endcase
    end
  end

  assign out_data   = out_data_q;
  assign out_header = out_header_q;
  assign out_valid  = out_valid_q;
  assign block_lock = lock_q;
  assign slip       = slip_q;

endmodule

// File: tb/tb_rx_descrambler_sync.sv
// Directed bench for rx_descrambler_sync: a reference scrambler feeds the DUT and
// expected payloads, lock and slip are stated per block.
module tb_rx_descrambler_sync;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] in_data;
  logic [1:0]  in_header;
  logic        in_valid;
  logic [63:0] out_data;
  logic [1:0]  out_header;
  logic        out_valid;
  logic        block_lock;
  logic        slip;

  int checks;
  int errors;

  // Reference scrambler history: scr_q[57] is the newest transmitted bit
  logic [57:0] scr_q;

  localparam logic [63:0] Idle = 64'h0000_0000_0000_001E;

  always #5 clk = ~clk;

  rx_descrambler_sync #(
    .PCS_DATA_WIDTH (64),
    .SLIP_WAIT      (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_header  (in_header),
    .in_valid   (in_valid),
    .out_data   (out_data),
    .out_header (out_header),
    .out_valid  (out_valid),
    .block_lock (block_lock),
    .slip       (slip)
  );

  function automatic logic [63:0] pat(input int k);
    return 64'h0123_4567_89AB_CDEF + (64'(k) * 64'h9E37_79B9_7F4A_7C15);
  endfunction

  // s[n] = d[n] ^ s[n-39] ^ s[n-58]
  task automatic scramble(input logic [63:0] d, output logic [63:0] s);
    logic b;
    s = '0;
    for (int i = 0; i < 64; i++) begin
      b     = d[i] ^ scr_q[19] ^ scr_q[0];
      s[i]  = b;
      scr_q = {b, scr_q[57:1]};
    end
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs and sample #1 after the edge
  task automatic step(input logic r, input logic v, input logic [63:0] dat,
                      input logic [1:0] hdr);
    rst       = r;
    in_valid  = v;
    in_data   = dat;
    in_header = hdr;
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".valid"}, 64'(out_valid), 64'd0);
    check({tag, ".data"}, out_data, 64'd0);
    check({tag, ".hdr"}, 64'(out_header), 64'd0);
    check({tag, ".lock"}, 64'(block_lock), 64'd0);
    check({tag, ".slip"}, 64'(slip), 64'd0);
  endtask

  // Scramble d, send it as a valid block, then check the block that comes out
  task automatic send(input string tag, input logic [63:0] d, input logic [1:0] hdr,
                      input logic exp_lock, input logic exp_slip);
    logic [63:0] s;
    scramble(d, s);
    step(1'b0, 1'b1, s, hdr);
    check({tag, ".valid"}, 64'(out_valid), 64'd1);
    check({tag, ".data"}, out_data, d);
    check({tag, ".hdr"}, 64'(out_header), 64'(hdr));
    check({tag, ".lock"}, 64'(block_lock), 64'(exp_lock));
    check({tag, ".slip"}, 64'(slip), 64'(exp_slip));
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    in_valid  = 1'b1;
    in_data   = 64'hFFFF_0000_FFFF_0000;
    in_header = 2'b10;

    // Reset held three cycles with valid input present
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      check_zero($sformatf("rst%0d", c));
    end
    scr_q = '1;

    // Round trip of idle blocks; lock on the 65th valid block after release
    for (int k = 0; k <= 64; k++) begin
      send($sformatf("A%0d", k), Idle, 2'b10, (k == 64), 1'b0);
    end

    // Locked window with 15 invalid headers: lock holds
    for (int j = 0; j < 64; j++) begin
      send($sformatf("B%0d", j), pat(j), (j < 15) ? 2'b11 : 2'b01, 1'b1, 1'b0);
    end

    // Fresh window: 16 invalid headers, lock drops and slip pulses on the 16th
    for (int j = 0; j <= 30; j++) begin
      send($sformatf("C%0d", j), pat(100 + j), (j % 2 == 0) ? 2'b00 : 2'b10,
           (j < 30), (j == 30));
    end
    send("C31", pat(131), 2'b01, 1'b0, 1'b0);

    // Reset while in slip hold, with a valid block on the reset edge
    step(1'b1, 1'b1, pat(200), 2'b01);
    check_zero("rstD");
    scr_q = '1;

    // Unlocked slip on block 10; blocks 11..14 ignored; block 15 restarts counting
    for (int k = 0; k <= 79; k++) begin
      send($sformatf("D%0d", k), pat(300 + k), (k >= 10 && k <= 14) ? 2'b00 : 2'b01,
           (k == 79), (k == 10));
    end

    // Reset, then the same lock sequence with in_valid low on alternate cycles
    step(1'b1, 1'b0, pat(400), 2'b10);
    check_zero("rstE");
    scr_q = '1;
    for (int k = 0; k <= 64; k++) begin
      step(1'b0, 1'b0, 64'hDEAD_BEEF_0BAD_F00D, 2'b11);
      check($sformatf("Egap%0d.valid", k), 64'(out_valid), 64'd0);
      check($sformatf("Egap%0d.lock", k), 64'(block_lock), 64'd0);
      check($sformatf("Egap%0d.slip", k), 64'(slip), 64'd0);
      send($sformatf("E%0d", k), Idle, 2'b10, (k == 64), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
